// File: rtl/matrix_chunk_loader.sv
// Responder for the matrix SRAM: on request, reads BANDWIDTH consecutive weights one per cycle
// into a wide packed chunk held on matrix_data; independent preload write port.
module matrix_chunk_loader #(
  parameter int NUM_ROWS   = 64,
  parameter int NUM_COLS   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int BANDWIDTH  = 16,
  localparam int DEPTH     = NUM_ROWS * NUM_COLS,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            matrix_enable,
  input  logic [AW-1:0]                   matrix_addr,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] matrix_data,
  output logic                            matrix_ready,
  input  logic                            mem_we,
  input  logic [AW-1:0]                   mem_waddr,
  input  logic [DATA_WIDTH-1:0]           mem_wdata,
  output logic                            busy
);

  localparam int KW = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [KW-1:0] K_LAST = KW'(BANDWIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_READY} state_t;

  state_t                          state_q, state_d;
  logic [AW-1:0]                   base_q, base_d;
  logic [KW-1:0]                   k_q, k_d;
  logic                            ready_q, ready_d;
  logic [DATA_WIDTH*BANDWIDTH-1:0] data_q, data_d;
  logic                            rd_vld_q, rd_vld_d;
  logic [KW-1:0]                   rd_lane_q, rd_lane_d;
  logic                            rd_oob_q, rd_oob_d;
  logic [DATA_WIDTH-1:0]           rd_raw_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address is one bit wider so reads past the end fall out of range instead of wrapping.
  logic [AW:0] rd_addr_ext;
  logic        rd_oob;
  logic        rd_en;
  logic        lane_we;
  logic [DATA_WIDTH-1:0] lane_word;

  assign rd_addr_ext = {1'b0, base_q} + (AW+1)'(k_q);
  assign rd_oob      = (rd_addr_ext >= DEPTH_W);
  assign rd_en       = (state_q == S_FETCH) && matrix_enable;
  assign lane_word   = rd_oob_q ? '0 : rd_raw_q;
  assign lane_we     = rd_vld_q && matrix_enable &&
                       ((state_q == S_FETCH) || (state_q == S_DRAIN));

  // Storage is never reset; a same-cycle write leaves the read returning the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (rd_en && !rd_oob) begin
      rd_raw_q <= mem[rd_addr_ext[AW-1:0]];
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    k_d       = k_q;
    ready_d   = 1'b0;
    data_d    = data_q;
    rd_vld_d  = 1'b0;
    rd_lane_d = rd_lane_q;
    rd_oob_d  = rd_oob_q;

    for (int i = 0; i < BANDWIDTH; i++) begin
      if (lane_we && (rd_lane_q == KW'(i))) begin
        data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_word;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (matrix_enable) begin
          base_d  = matrix_addr;
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!matrix_enable) begin
          state_d = S_IDLE;
        end else begin
          rd_vld_d  = 1'b1;
          rd_lane_d = k_q;
          rd_oob_d  = rd_oob;
          k_d       = k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = matrix_enable ? S_READY : S_IDLE;
      end
      S_READY: begin
        if (matrix_enable) begin
          ready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      k_q       <= '0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_lane_q <= '0;
      rd_oob_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      k_q       <= k_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      rd_vld_q  <= rd_vld_d;
      rd_lane_q <= rd_lane_d;
      rd_oob_q  <= rd_oob_d;
    end
  end

  assign matrix_data  = data_q;
  assign matrix_ready = ready_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_chunk_loader.sv
// Bench for matrix_chunk_loader: shadow-memory model, table of fetch vectors, scoreboard queue,
// and hand-written reset / hold / abort / collision sequences.
module tb_matrix_chunk_loader;
  localparam int DW    = 16;
  localparam int BW    = 16;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int CW    = DW * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          matrix_enable;
  logic [AW-1:0] matrix_addr;
  logic [CW-1:0] matrix_data;
  logic          matrix_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          busy;

  matrix_chunk_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .matrix_enable(matrix_enable),
    .matrix_addr  (matrix_addr),
    .matrix_data  (matrix_data),
    .matrix_ready (matrix_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] shadow [DEPTH];
  logic [CW-1:0] exp_q [$];

  typedef struct {
    int            addr;
    logic [CW-1:0] exp;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [CW-1:0] model_chunk(input int base);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < BW; k++) begin
      if (base + k < DEPTH) r[k*DW +: DW] = shadow[base + k];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Starts at a negedge, leaves enable high once ready is seen.
  task automatic fetch(input int addr, input logic [CW-1:0] exp, input int coll_cyc,
                       input int coll_addr, input logic [DW-1:0] coll_val);
    int   cnt;
    logic got;
    logic [CW-1:0] want;
    matrix_enable = 1'b1;
    matrix_addr   = AW'(addr);
    exp_q.push_back(exp);
    cnt = 0;
    got = 1'b0;
    while (cnt < 40 && !got) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("busy_after_start", CW'(busy), CW'(1));
        matrix_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      mem_we = (cnt == coll_cyc);
      if (cnt == coll_cyc) begin
        mem_waddr = AW'(coll_addr);
        mem_wdata = coll_val;
        shadow[coll_addr] = coll_val;
      end
      if (matrix_ready) got = 1'b1;
    end
    mem_we = 1'b0;
    check("ready_latency", CW'(cnt), CW'(19));
    want = exp_q.pop_front();
    if (got) check("chunk_data", matrix_data, want);
  endtask

  task automatic release_req();
    matrix_enable = 1'b0;
    matrix_addr   = AW'(128);
    @(negedge clk);
    check("ready_drop", CW'(matrix_ready), CW'(0));
    check("busy_drop", CW'(busy), CW'(0));
  endtask

  initial begin
    logic [CW-1:0] saved, mask, exp_abort;
    int            ready_seen;

    rst_n = 1'b0;
    matrix_enable = 1'b0;
    matrix_addr = '0;
    mem_we = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    #12;
    check("reset_ready", CW'(matrix_ready), CW'(0));
    check("reset_busy", CW'(busy), CW'(0));
    check("reset_data", matrix_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      mem_we = 1'b1;
      mem_waddr = AW'(i);
      mem_wdata = DW'(i);
      shadow[i] = DW'(i);
    end
    @(negedge clk);
    mem_we = 1'b0;

    // Basic fetch, then hold with enable high, then release and check the chunk persists.
    saved = model_chunk(64);
    fetch(64, saved, -1, 0, '0);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", CW'(matrix_ready), CW'(1));
    end
    check("hold_no_refetch", matrix_data, saved);
    release_req();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0 || c == 19) check("data_persist", matrix_data, saved);
    end

    // Collision: write to word 70 sampled on the same edge that reads it.
    fetch(64, model_chunk(64), 7, 70, 16'hBEEF);
    release_req();
    fetch(64, model_chunk(64), -1, 0, '0);
    check("collision_new_lane6", CW'(matrix_data[6*DW +: DW]), CW'(16'hBEEF));
    release_req();

    vecs[0] = '{addr: 0,    exp: model_chunk(0)};
    vecs[1] = '{addr: 4088, exp: model_chunk(4088)};
    vecs[2] = '{addr: 4095, exp: model_chunk(4095)};
    vecs[3] = '{addr: 4080, exp: model_chunk(4080)};
    vecs[4] = '{addr: 1000, exp: model_chunk(1000)};
    vecs[5] = '{addr: 70,   exp: model_chunk(70)};
    for (int v = 0; v < 6; v++) begin
      fetch(vecs[v].addr, vecs[v].exp, -1, 0, '0);
      release_req();
    end

    // Abort after five fetch cycles: lanes 0..3 new, 5..15 old, lane 4 not checked.
    saved = matrix_data;
    matrix_enable = 1'b1;
    matrix_addr = AW'(2000);
    repeat (6) @(negedge clk);
    matrix_enable = 1'b0;
    ready_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (matrix_ready) ready_seen++;
    end
    check("abort_no_ready", CW'(ready_seen), CW'(0));
    check("abort_busy", CW'(busy), CW'(0));
    exp_abort = saved;
    for (int k = 0; k < 4; k++) exp_abort[k*DW +: DW] = shadow[2000 + k];
    mask = '1;
    mask[4*DW +: DW] = '0;
    check("abort_lanes", matrix_data & mask, exp_abort & mask);
    fetch(0, model_chunk(0), -1, 0, '0);
    release_req();

    // Asynchronous reset in the middle of a fetch.
    matrix_enable = 1'b1;
    matrix_addr = AW'(500);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ready", CW'(matrix_ready), CW'(0));
    check("midreset_busy", CW'(busy), CW'(0));
    check("midreset_data", matrix_data, '0);
    matrix_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(500, model_chunk(500), -1, 0, '0);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
